// File: rtl/riscof_tb_ctrl_periph.sv
// riscof_tb_ctrl_periph
//   Memory-mapped testbench control peripheral for the RISCOF cv32e40p
//   wrapper. Firmware loads and stores into a 32-byte window give access to
//   a stdout character FIFO, sticky pass/fail flags, a one-shot exit code,
//   a free-running 64-bit cycle counter and a scratch register.
//
//   Ports
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     data_req_i / data_gnt_o       request (pre-decoded to this window) and grant
//     data_rvalid_o / data_rdata_o  registered response, one cycle after grant
//     data_addr_i, data_we_i,
//     data_be_i, data_wdata_i       request address, direction, byte enables, data
//     stdout_valid_o/char_o/ready_i stdout FIFO head, popped on valid & ready
//     tests_passed_o/tests_failed_o sticky status flags
//     exit_valid_o/exit_value_o     sticky exit flag and latched exit code
//
//   Register offsets (addr[4:2]):
//     0x00 STDOUT(W) 0x04 EXIT(W) 0x08 STATUS(W) 0x0C CYCLE_LO(R)
//     0x10 CYCLE_HI(R) 0x14 SCRATCH(R/W) 0x18/0x1C reserved

module riscof_tb_ctrl_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] OFF_STDOUT  = 3'd0;
  localparam logic [2:0] OFF_EXIT    = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_CYC_LO  = 3'd3;
  localparam logic [2:0] OFF_CYC_HI  = 3'd4;
  localparam logic [2:0] OFF_SCRATCH = 3'd5;

  logic [2:0]       offset;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             wr_grant;
  logic             rd_grant;
  logic [31:0]      rd_val;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [63:0]      cycle_cnt;
  logic [31:0]      cycle_hi_shadow;
  logic [31:0]      scratch;

  logic             rvalid_p1;
  logic [31:0]      rdata_p1;

  // The wrapper has already decoded the window, so only addr[4:2] matters.
  logic unused_bits;
  assign unused_bits = ^{data_addr_i[31:5], data_addr_i[1:0], BASE_ADDR};

  assign offset     = data_addr_i[4:2];
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);

  // Fullness is taken before any same-cycle pop, so a blocked push waits a
  // full cycle after space appears.
  assign data_gnt_o = data_req_i &
                      ~(data_we_i & (offset == OFF_STDOUT) & data_be_i[0] & fifo_full);
  assign wr_grant   = data_gnt_o & data_we_i;
  assign rd_grant   = data_gnt_o & ~data_we_i;

  assign push = wr_grant & (offset == OFF_STDOUT) & data_be_i[0];
  assign pop  = ~fifo_empty & stdout_ready_i;

  assign stdout_valid_o = ~fifo_empty;
  assign stdout_char_o  = fifo_mem[rd_ptr];

  assign data_rvalid_o = rvalid_p1;
  assign data_rdata_o  = rdata_p1;

  always_comb begin
    rd_val = 32'h0;
    case (offset)
      OFF_CYC_LO:  rd_val = cycle_cnt[31:0];
      OFF_CYC_HI:  rd_val = cycle_hi_shadow;
      OFF_SCRATCH: rd_val = scratch;
      3'd6, 3'd7:  rd_val = 32'hDEAD_BEEF;
      default:     rd_val = 32'h0;
    endcase
  end

  // ---- stage p0 -> p1: request accepted, response registered ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= 32'h0;
    end else begin
      rvalid_p1 <= data_gnt_o;
      rdata_p1  <= rd_grant ? rd_val : 32'h0;
    end
  end

  // FIFO storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= 32'h0;
      scratch        <= 32'h0;
    end else begin
      if (wr_grant && offset == OFF_STATUS) begin
        if (data_wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
        else                            tests_failed_o <= 1'b1;
      end
      // Only the first exit code is kept.
      if (wr_grant && offset == OFF_EXIT && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= data_wdata_i;
      end
      if (wr_grant && offset == OFF_SCRATCH) begin
        for (int b = 0; b < 4; b++) begin
          if (data_be_i[b]) scratch[8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Reading CYCLE_LO freezes the matching high word so LO-then-HI is coherent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt       <= 64'h0;
      cycle_hi_shadow <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (rd_grant && offset == OFF_CYC_LO) cycle_hi_shadow <= cycle_cnt[63:32];
    end
  end

endmodule

// File: tb/tb_riscof_tb_ctrl_periph.sv
`timescale 1ns/1ps
module tb_riscof_tb_ctrl_periph;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        stdout_valid_o;
  logic [7:0]  stdout_char_o;
  logic        stdout_ready_i;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  riscof_tb_ctrl_periph #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(4), .PASS_MAGIC(MAGIC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .stdout_valid_o(stdout_valid_o), .stdout_char_o(stdout_char_o),
    .stdout_ready_i(stdout_ready_i),
    .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
    .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Capture popped characters between edges, after stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (rst_ni && stdout_valid_o && stdout_ready_i) seen.push_back(stdout_char_o);
  end

  // Call at a falling edge; returns at a falling edge with the response sampled.
  task automatic bus(input logic we, input logic [4:0] off, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd);
    int n;
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = BASE + {27'b0, off};
    data_be_i    = be;
    data_wdata_i = wd;
    #1;
    n = 0;
    while (!data_gnt_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!data_gnt_o) begin
      check("gnt_timeout", {31'b0, data_gnt_o}, 32'h1);
      data_req_i = 1'b0;
      rd = 32'h0;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    data_req_i = 1'b0;
    check("rvalid", {31'b0, data_rvalid_o}, 32'h1);
    rd = data_rdata_o;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] wd);
    logic [31:0] d;
    bus(1'b1, off, 4'hF, wd, d);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, off, 4'hF, 32'h0, d);
    check(tag, d, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] lo, hi;
    rst_ni = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = BASE;
    data_be_i = 4'h0; data_wdata_i = 32'h0; stdout_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    check("rst_rdata", data_rdata_o, 32'h0);
    check("rst_stdout_valid", {31'b0, stdout_valid_o}, 32'h0);
    check("rst_flags", {28'b0, tests_passed_o, tests_failed_o, exit_valid_o, 1'b0}, 32'h0);
    check("rst_exit_value", exit_value_o, 32'h0);

    // "Hi\n" streamed out with consumer always ready
    stdout_ready_i = 1'b1;
    seen.delete();
    wr(5'h00, 32'h48); wr(5'h00, 32'h69); wr(5'h00, 32'h0A);
    repeat (3) @(negedge clk);
    check("hi_count", seen.size(), 32'd3);
    if (seen.size() == 3) begin
      check("hi_c0", {24'b0, seen[0]}, 32'h48);
      check("hi_c1", {24'b0, seen[1]}, 32'h69);
      check("hi_c2", {24'b0, seen[2]}, 32'h0A);
    end
    check("hi_drained", {31'b0, stdout_valid_o}, 32'h0);

    // Backpressure: four fill the FIFO, the fifth waits
    stdout_ready_i = 1'b0;
    seen.delete();
    for (int i = 0; i < 4; i++) wr(5'h00, 32'h41 + i);
    check("full_head", {23'b0, stdout_valid_o, stdout_char_o}, 32'h141);
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE; data_be_i = 4'h1;
    data_wdata_i = 32'h45;
    #1; check("full_gnt0", {31'b0, data_gnt_o}, 32'h0);
    @(negedge clk); #1; check("full_gnt1", {31'b0, data_gnt_o}, 32'h0);
    @(negedge clk); stdout_ready_i = 1'b1;
    #1; check("pop_same_cycle_gnt", {31'b0, data_gnt_o}, 32'h0);
    @(negedge clk); stdout_ready_i = 1'b0;
    #1; check("after_pop_gnt", {31'b0, data_gnt_o}, 32'h1);
    @(posedge clk); @(negedge clk);
    data_req_i = 1'b0;
    check("fifth_rvalid", {31'b0, data_rvalid_o}, 32'h1);
    stdout_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    stdout_ready_i = 1'b0;
    check("bp_count", seen.size(), 32'd5);
    if (seen.size() == 5)
      for (int i = 0; i < 5; i++) check("bp_order", {24'b0, seen[i]}, 32'h41 + i);

    // STDOUT write without byte 0 enabled is dropped
    begin
      logic [31:0] d;
      bus(1'b1, 5'h00, 4'hE, 32'h5A, d);
    end
    check("be0_off_ignored", {31'b0, stdout_valid_o}, 32'h0);

    // Status pass
    wr(5'h08, MAGIC);
    check("pass_flag", {30'b0, tests_passed_o, tests_failed_o}, 32'h2);
    // Separate run: fail, then both set
    do_reset();
    @(negedge clk);
    wr(5'h08, 32'h1);
    check("fail_flag", {30'b0, tests_passed_o, tests_failed_o}, 32'h1);
    wr(5'h08, MAGIC);
    check("both_flags", {30'b0, tests_passed_o, tests_failed_o}, 32'h3);

    // Exit: first write wins
    wr(5'h04, 32'h0); wr(5'h04, 32'h5);
    check("exit_valid", {31'b0, exit_valid_o}, 32'h1);
    check("exit_value0", exit_value_o, 32'h0);
    do_reset();
    @(negedge clk);
    wr(5'h04, 32'hCAFE_0001); wr(5'h04, 32'h5);
    check("exit_value1", exit_value_o, 32'hCAFE_0001);

    // Register map reads
    rd_chk("rd_stdout", 5'h00, 32'h0);
    rd_chk("rd_exit", 5'h04, 32'h0);
    rd_chk("rd_status", 5'h08, 32'h0);
    wr(5'h14, 32'h1122_3344);
    rd_chk("scratch_full", 5'h14, 32'h1122_3344);
    begin
      logic [31:0] d;
      bus(1'b1, 5'h14, 4'b0101, 32'hAABB_CCDD, d);
    end
    rd_chk("scratch_be", 5'h14, 32'h11BB_33DD);
    wr(5'h18, 32'h0);
    rd_chk("rsvd_18", 5'h18, 32'hDEAD_BEEF);
    rd_chk("rsvd_1c", 5'h1C, 32'hDEAD_BEEF);

    // Cycle counter carry across the low word
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    bus(1'b0, 5'h0C, 4'hF, 32'h0, lo);
    bus(1'b0, 5'h10, 4'hF, 32'h0, hi);
    check("cyc_lo_pre", lo, 32'hFFFF_FFFE);
    check("cyc_hi_pre", hi, 32'h0);
    bus(1'b0, 5'h0C, 4'hF, 32'h0, lo);
    bus(1'b0, 5'h10, 4'hF, 32'h0, hi);
    check("cyc_lo_post", lo, 32'h0);
    check("cyc_hi_post", hi, 32'h1);

    // Reset in the middle of a granted read
    wr(5'h00, 32'h5A);
    wr(5'h08, MAGIC);
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = BASE + 32'h14; data_be_i = 4'hF;
    @(posedge clk); #1;
    data_req_i = 1'b0;
    check("mid_rvalid_up", {31'b0, data_rvalid_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    check("mid_rvalid_drop", {31'b0, data_rvalid_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_rvalid0", {31'b0, data_rvalid_o}, 32'h0);
    @(negedge clk);
    check("post_rvalid1", {31'b0, data_rvalid_o}, 32'h0);
    check("post_rdata", data_rdata_o, 32'h0);
    check("post_fifo", {31'b0, stdout_valid_o}, 32'h0);
    check("post_flags", {29'b0, tests_passed_o, tests_failed_o, exit_valid_o}, 32'h0);
    check("post_exit_value", exit_value_o, 32'h0);
    rd_chk("post_scratch", 5'h14, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/riscof_tb_ctrl_periph.md
Name: riscof_tb_ctrl_periph

Overview:
Memory-mapped testbench control peripheral on the core data bus inside the RISCOF cv32e40p tb wrapper. It decodes firmware stores and loads to a small register window and provides the following:
- buffered stdout characters
- sticky pass/fail flags
- exit valid/value
- a readable 64-bit cycle counter

It directly produces tests_passed_o, tests_failed_o, exit_valid_o and exit_value_o, which the verilator top-level consumes to end simulation.

Parameters:
BASE_ADDR, 32'h2000_0000, base of the 32-byte register window; the block claims addresses BASE_ADDR..BASE_ADDR+0x1F.
FIFO_DEPTH, 4, stdout character FIFO entries; power of two, minimum 2.
PASS_MAGIC, 32'd123456789, value written to the STATUS register that signals pass.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
data_req_i  input  1  bus request, already address-decoded to this window by the wrapper
data_gnt_o  output  1  request accepted this cycle
data_rvalid_o  output  1  response valid, one cycle after grant
data_addr_i  input  32  byte address
data_we_i  input  1  1 = write
data_be_i  input  4  byte enables
data_wdata_i  input  32  write data
data_rdata_o  output  32  read data, valid with data_rvalid_o
stdout_valid_o  output  1  character available
stdout_char_o  output  8  FIFO head character
stdout_ready_i  input  1  consumer pops when valid & ready
tests_passed_o  output  1  sticky pass flag
tests_failed_o  output  1  sticky fail flag
exit_valid_o  output  1  sticky exit flag
exit_value_o  output  32  latched exit code

Behaviour:
- Reset: all outputs 0; FIFO empty; counter 0; scratch 0; cycle_hi shadow 0.
- Offsets are taken from data_addr_i[4:2].
- Register map:
  - 0x00 STDOUT: W only; reads as 0.
  - 0x04 EXIT: W only.
  - 0x08 STATUS: W only.
  - 0x0C CYCLE_LO: R only.
  - 0x10 CYCLE_HI: R only.
  - 0x14 SCRATCH: R/W, honours byte enables.
  - 0x18 and 0x1C: reserved; reads return 32'hDEAD_BEEF, writes are ignored.
- Grant is combinational: data_gnt_o = data_req_i & ~(we & offset==STDOUT & be[0] & fifo_full).
- A pop in the same cycle does not free space for a blocked push.
- data_rvalid_o is registered and pulses exactly 1 cycle after every granted request, for reads and writes alike.
- data_rdata_o holds the value sampled at grant time. It is 0 when rvalid is low.
- Back-to-back granted requests give back-to-back rvalid pulses. No outstanding-request limit beyond 1 per cycle.
- STDOUT write with be[0]=1: push wdata[7:0] into the FIFO. With be[0]=0 the write is ignored but still granted.
- FIFO:
  - FIFO_DEPTH entries; stdout_valid_o = ~empty; stdout_char_o = head.
  - Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- EXIT write, any be:
  - If exit_valid_o==0: latch the full wdata into exit_value_o and set exit_valid_o on the next edge.
  - Later EXIT writes are ignored.
- STATUS write:
  - wdata==PASS_MAGIC sets tests_passed_o.
  - Any other value sets tests_failed_o.
  - Both flags are sticky until reset and can both end up set.
- Cycle counter:
  - 64-bit, free-running, +1 every clock after reset release; wraps at 2^64-1 to 0.
  - Reading CYCLE_LO returns the low word and snapshots the high word into the shadow in the same cycle.
  - Reading CYCLE_HI returns the shadow, so an LO-then-HI sequence is coherent.
- Writes to read-only registers are ignored; reads of write-only registers return 0.
- Asynchronous reset mid-transaction:
  - rvalid is dropped immediately.
  - The FIFO is flushed.
  - Sticky flags are cleared.
  - No pending response is replayed after reset.

Test Plan:
- Write 0x48, 0x69, 0x0A to STDOUT with stdout_ready_i=1 -> stdout_valid_o pulses carrying chars 'H','i','\n' in order; every write gets gnt the same cycle and rvalid 1 cycle later.
- stdout_ready_i=0, five STDOUT writes with FIFO_DEPTH=4 -> the first 4 are granted; the 5th has gnt=0 until ready=1 for one cycle, then is granted the following cycle; output order is preserved.
- Write PASS_MAGIC to STATUS -> tests_passed_o=1 on the next cycle, tests_failed_o=0. A separate run writing 0x1 -> tests_failed_o=1.
- Write 0x0 then 0x5 to EXIT -> exit_valid_o=1 and exit_value_o=0; the second write is ignored.
- Counter preset by force to 0x0000_0000_FFFF_FFFE, then read LO then HI -> LO=0xFFFF_FFFF-range value and HI consistent with that LO sample, i.e. 0 if LO was sampled before the carry, 1 if after.
- Assert rst_ni low during a granted read -> no rvalid after release; all outputs 0; FIFO empty; SCRATCH reads 0.
